// File: rtl/pcs_rx_pkg.sv
// rtl/pcs_rx_pkg.sv - shared 10GBASE-R receive types and block-lock defaults
package pcs_rx_pkg;

  typedef logic [1:0] sh_t;

  localparam sh_t SH_DATA = 2'b01;
  localparam sh_t SH_CTRL = 2'b10;

  typedef enum logic [1:0] {INIT, TEST, SLIP, WAIT} lock_state_t;

  localparam int LOCK_CNT_DEF  = 64;
  localparam int BAD_MAX_DEF   = 16;
  localparam int SLIP_WAIT_DEF = 32;

  function automatic logic sh_valid(input sh_t sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/block_lock_32b.sv
// rtl/block_lock_32b.sv - sync-header block-lock FSM with gearbox slip requests
module block_lock_32b
  import pcs_rx_pkg::*;
#(
  parameter int LOCK_CNT  = LOCK_CNT_DEF,
  parameter int BAD_MAX   = BAD_MAX_DEF,
  parameter int SLIP_WAIT = SLIP_WAIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ctrl,
  input  logic        hdr_en,
  output logic        slip,
  output logic        block_lock,
  output logic [15:0] slip_cnt
);

  localparam int SH_W   = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(BAD_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT);

  localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(LOCK_CNT);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(BAD_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

  lock_state_t       state, state_n;
  logic [SH_W-1:0]   sh_cnt, sh_n, sh_inc;
  logic [BAD_W-1:0]  bad_cnt, bad_n, bad_inc;
  logic [WAIT_W-1:0] wait_cnt, wait_n;
  logic              lock_n;
  logic              hdr_ok;

  assign hdr_ok  = sh_valid(ctrl);
  assign sh_inc  = sh_cnt + 1'b1;
  assign bad_inc = bad_cnt + {{(BAD_W-1){1'b0}}, ~hdr_ok};

  always_comb begin
    state_n = state;
    sh_n    = sh_cnt;
    bad_n   = bad_cnt;
    wait_n  = wait_cnt;
    lock_n  = block_lock;
    case (state)
      INIT: begin
        sh_n    = '0;
        bad_n   = '0;
        lock_n  = 1'b0;
        state_n = TEST;
      end
      TEST: begin
        if (hdr_en) begin
          if (!block_lock) begin
            if (!hdr_ok) begin
              state_n = SLIP;
            end else if (sh_inc == SH_LAST) begin
              lock_n = 1'b1;
              sh_n   = '0;
              bad_n  = '0;
            end else begin
              sh_n = sh_inc;
            end
          end else begin
            // Too many bad headers wins even when the window closes on the same strobe.
            if (bad_inc == BAD_LAST) begin
              lock_n  = 1'b0;
              state_n = SLIP;
            end else if (sh_inc == SH_LAST) begin
              sh_n  = '0;
              bad_n = '0;
            end else begin
              sh_n  = sh_inc;
              bad_n = bad_inc;
            end
          end
        end
      end
      SLIP: begin
        sh_n    = '0;
        bad_n   = '0;
        wait_n  = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (hdr_en) begin
          if (wait_cnt == WAIT_LAST) begin
            state_n = TEST;
            lock_n  = 1'b0;
          end else begin
            wait_n = wait_cnt + 1'b1;
          end
        end
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= INIT;
      sh_cnt     <= '0;
      bad_cnt    <= '0;
      wait_cnt   <= '0;
      block_lock <= 1'b0;
      slip       <= 1'b0;
      slip_cnt   <= '0;
    end else begin
      state      <= state_n;
      sh_cnt     <= sh_n;
      bad_cnt    <= bad_n;
      wait_cnt   <= wait_n;
      block_lock <= lock_n;
      slip       <= (state_n == SLIP);
      if (state == SLIP && slip_cnt != 16'hFFFF) begin
        slip_cnt <= slip_cnt + 16'd1;
      end
    end
  end

endmodule
